// File: rtl/iob_soc_sut_bringup_pkg.sv
// rtl/iob_soc_sut_bringup_pkg.sv - shared state encoding and counter sizing for the bring-up sequencer
//
// Holds the sequencer state encoding (visible on state_o for debug) and
// the helper that sizes the shared cycle counter from the cycle parameters.
package iob_soc_sut_bringup_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_PHY_RST    = 3'd2,
    ST_PHY_WAIT   = 3'd3,
    ST_WAIT_CALIB = 3'd4,
    ST_SYS_RST    = 3'd5,
    ST_RUN        = 3'd6,
    ST_FAULT      = 3'd7
  } state_e;

  // Width able to hold the largest of the cycle parameters.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/iob_sync.sv
// rtl/iob_sync.sv - two-flop synchronizer for a single asynchronous level
//
// Ports:
//   clk_i  destination clock
//   rst_i  synchronous active-high reset, clears both flops
//   d_i    asynchronous input level
//   q_o    synchronized level, two cycles behind d_i
module iob_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/iob_soc_sut_bringup_seq.sv
// rtl/iob_soc_sut_bringup_seq.sv - supervised board bring-up reset sequencer
//
// Waits for clock lock, pulses the Ethernet PHY reset, waits for DDR
// calibration (optional) and then releases the system reset. Lock loss
// restarts the sequence; a calibration timeout parks the block in FAULT
// until retry_i.
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous active-high reset
//   pll_locked_i  clock source locked (asynchronous)
//   calib_done_i  DDR calibration complete (asynchronous)
//   retry_i       single-cycle pulse, leaves FAULT
//   sys_rst_o     system reset, active-high
//   phy_resetn_o  Ethernet PHY reset, active-low
//   ready_o       high only in RUN
//   fault_o       high only in FAULT
//   state_o       current state encoding
module iob_soc_sut_bringup_seq
  import iob_soc_sut_bringup_pkg::*;
#(
  parameter int PHY_RST_CYCLES  = 16,
  parameter int PHY_WAIT_CYCLES = 32,
  parameter int CALIB_TIMEOUT   = 1000,
  parameter int SYS_RST_CYCLES  = 10,
  parameter int USE_DDR         = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pll_locked_i,
  input  logic               calib_done_i,
  input  logic               retry_i,
  output logic               sys_rst_o,
  output logic               phy_resetn_o,
  output logic               ready_o,
  output logic               fault_o,
  output logic [STATE_W-1:0] state_o
);

  localparam int CNT_W = cnt_width(PHY_RST_CYCLES, PHY_WAIT_CYCLES,
                                   CALIB_TIMEOUT, SYS_RST_CYCLES);

  localparam logic [CNT_W-1:0] PHY_RST_LAST  = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHY_WAIT_LAST = CNT_W'(PHY_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CALIB_LAST    = CNT_W'(CALIB_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SYS_RST_LAST  = CNT_W'(SYS_RST_CYCLES - 1);

  logic lock_s;
  logic calib_s;

  iob_sync u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pll_locked_i),
    .q_o   (lock_s)
  );

  iob_sync u_calib_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (calib_done_i),
    .q_o   (calib_s)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             sys_rst_q, sys_rst_d;
  logic             phy_resetn_q, phy_resetn_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;

  always_comb begin
    // Saturating increment: the counter never wraps back into a match.
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    state_d = state_q;
    cnt_d   = cnt_inc;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) state_d = ST_PHY_RST;
      end
      ST_PHY_RST: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == PHY_RST_LAST) begin
          state_d = ST_PHY_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PHY_WAIT: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == PHY_WAIT_LAST) begin
          state_d = (USE_DDR != 0) ? ST_WAIT_CALIB : ST_SYS_RST;
          cnt_d   = '0;
        end
      end
      ST_WAIT_CALIB: begin
        // Calibration success is checked before the timeout so it wins a tie.
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (calib_s) begin
          state_d = ST_SYS_RST;
          cnt_d   = '0;
        end else if (cnt_q == CALIB_LAST) begin
          state_d = ST_FAULT;
          cnt_d   = '0;
        end
      end
      ST_SYS_RST: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == SYS_RST_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lock_s) state_d = ST_WAIT_LOCK;
      end
      ST_FAULT: begin
        cnt_d = '0;
        if (retry_i) state_d = ST_WAIT_LOCK;
      end
    endcase

    // Outputs are decoded from the next state so the registered values
    // line up with state_q on the same cycle.
    sys_rst_d    = 1'b1;
    phy_resetn_d = 1'b0;
    ready_d      = 1'b0;
    fault_d      = 1'b0;
    case (state_d)
      ST_PHY_WAIT, ST_WAIT_CALIB, ST_SYS_RST: phy_resetn_d = 1'b1;
      ST_RUN: begin
        sys_rst_d    = 1'b0;
        phy_resetn_d = 1'b1;
        ready_d      = 1'b1;
      end
      ST_FAULT: fault_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sys_rst_q    <= 1'b1;
      phy_resetn_q <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sys_rst_q    <= sys_rst_d;
      phy_resetn_q <= phy_resetn_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  assign sys_rst_o    = sys_rst_q;
  assign phy_resetn_o = phy_resetn_q;
  assign ready_o      = ready_q;
  assign fault_o      = fault_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_iob_soc_sut_bringup_seq.sv
// tb/tb_iob_soc_sut_bringup_seq.sv - scoreboard bench for the bring-up sequencer
module tb_iob_soc_sut_bringup_seq;

  localparam int S_IDLE = 0, S_WL = 1, S_PR = 2, S_PW = 3;
  localparam int S_WC = 4, S_SR = 5, S_RUN = 6, S_FAULT = 7;
  localparam int PR = 16, PW = 32, CT = 1000, SR = 10;
  localparam int NEVER = 1 << 30;

  typedef struct {
    int st;
    int t;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  logic       rst0 = 1'b1, pll0 = 1'b1, calib0 = 1'b1, retry0 = 1'b0;
  logic       sys0, phy0, rdy0, flt0;
  logic [2:0] st0;
  logic       rst1 = 1'b1, pll1 = 1'b1, calib1 = 1'b0, retry1 = 1'b0;
  logic       sys1, phy1, rdy1, flt1;
  logic [2:0] st1;

  iob_soc_sut_bringup_seq #(
    .PHY_RST_CYCLES(PR), .PHY_WAIT_CYCLES(PW), .CALIB_TIMEOUT(CT),
    .SYS_RST_CYCLES(SR), .USE_DDR(1)
  ) dut0 (
    .clk_i(clk), .rst_i(rst0), .pll_locked_i(pll0), .calib_done_i(calib0),
    .retry_i(retry0), .sys_rst_o(sys0), .phy_resetn_o(phy0), .ready_o(rdy0),
    .fault_o(flt0), .state_o(st0)
  );

  iob_soc_sut_bringup_seq #(
    .PHY_RST_CYCLES(PR), .PHY_WAIT_CYCLES(PW), .CALIB_TIMEOUT(CT),
    .SYS_RST_CYCLES(SR), .USE_DDR(0)
  ) dut1 (
    .clk_i(clk), .rst_i(rst1), .pll_locked_i(pll1), .calib_done_i(calib1),
    .retry_i(retry1), .sys_rst_o(sys1), .phy_resetn_o(phy1), .ready_o(rdy1),
    .fault_o(flt1), .state_o(st1)
  );

  int   tests = 0;
  int   fails = 0;
  ev_t  q0[$];
  ev_t  q1[$];
  logic [2:0] prev_st [2];
  int   model_st [2] = '{-1, -1};

  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp_v);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // {sys_rst, phy_resetn, ready, fault} required in each state
  function automatic int exp_outs(input int s);
    case (s)
      S_RUN:            return 4'b0110;
      S_FAULT:          return 4'b1001;
      S_PW, S_WC, S_SR: return 4'b1100;
      default:          return 4'b1000;
    endcase
  endfunction

  task automatic push(input int id, input int st, input int t, input int cut);
    ev_t e;
    if (t >= cut) return;
    e.st = st;
    e.t  = t;
    if (id == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Reference plan: from the edge PHY_RST is entered, derive every later
  // state entry from the phase lengths. calib_vis is the first edge the
  // sequencer can see calibration done. Events at or after cut are dropped.
  task automatic plan(input int id, input int t_pr, input int calib_vis,
                      input bit ddr, input int cut, output int t_end);
    int w, s;
    push(id, S_PR, t_pr, cut);
    push(id, S_PW, t_pr + PR, cut);
    w = t_pr + PR + PW;
    if (!ddr) begin
      push(id, S_SR, w, cut);
      t_end = w + SR;
      push(id, S_RUN, t_end, cut);
    end else begin
      push(id, S_WC, w, cut);
      s = imax(w + 1, calib_vis);
      if (s <= w + CT) begin
        push(id, S_SR, s, cut);
        t_end = s + SR;
        push(id, S_RUN, t_end, cut);
      end else begin
        t_end = w + CT;
        push(id, S_FAULT, t_end, cut);
      end
    end
  endtask

  task automatic mon(input int id, input logic [2:0] st, input logic [3:0] outs);
    ev_t e;
    bit  chg, due, have;
    chg  = (st !== prev_st[id]);
    prev_st[id] = st;
    have = 1'b0;
    if (id == 0) begin
      due = (q0.size() > 0) && (q0[0].t <= edge_n);
      if ((chg || due) && q0.size() > 0) begin
        e = q0.pop_front();
        have = 1'b1;
      end
    end else begin
      due = (q1.size() > 0) && (q1[0].t <= edge_n);
      if ((chg || due) && q1.size() > 0) begin
        e = q1.pop_front();
        have = 1'b1;
      end
    end
    if (have) begin
      chk($sformatf("dut%0d_state", id), int'(st), e.st);
      chk($sformatf("dut%0d_entry_edge", id), edge_n, e.t);
      model_st[id] = e.st;
    end else if (chg) begin
      chk($sformatf("dut%0d_unexpected_change", id), int'(st), model_st[id]);
    end
    if (model_st[id] >= 0)
      chk($sformatf("dut%0d_outputs", id), int'(outs), exp_outs(model_st[id]));
  endtask

  always @(negedge clk) begin
    mon(0, st0, {sys0, phy0, rdy0, flt0});
    mon(1, st1, {sys1, phy1, rdy1, flt1});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic proc0();
    int r, p, d, d2, k, t_end, w, fr, len, off, late;
    int offs[4] = '{16, 48, 49, 59};

    // Nominal DDR flow out of reset
    push(0, S_IDLE, 1, NEVER);
    step($urandom_range(3, 6));
    rst0 = 1'b0;
    r = edge_n;
    push(0, S_WL, r + 1, NEVER);
    plan(0, r + 3, r + 3, 1'b1, NEVER, t_end);
    step(t_end + 3 - edge_n);

    // Lock loss in RUN; retry pulses outside FAULT are ignored
    for (int it = 0; it < 3; it++) begin
      retry0 = 1'b1;
      step(1);
      retry0 = 1'b0;
      len = (it == 0) ? 5 : $urandom_range(1, 8);
      d = edge_n;
      pll0 = 1'b0;
      push(0, S_WL, d + 3, NEVER);
      step(len);
      pll0 = 1'b1;
      p = edge_n;
      plan(0, p + 3, 0, 1'b1, NEVER, t_end);
      step(t_end + 3 - edge_n);
    end

    // Lock loss at assorted points of the sequence, including phase ends
    d = edge_n;
    pll0 = 1'b0;
    push(0, S_WL, d + 3, NEVER);
    step(3);
    pll0 = 1'b1;
    p = edge_n;
    for (int it = 0; it < 6; it++) begin
      off = (it < 4) ? offs[it] : $urandom_range(1, 59);
      d2 = p + off;
      plan(0, p + 3, 0, 1'b1, d2 + 3, t_end);
      step(d2 - edge_n);
      pll0 = 1'b0;
      push(0, S_WL, d2 + 3, NEVER);
      step(2);
      pll0 = 1'b1;
      p = edge_n;
    end
    plan(0, p + 3, 0, 1'b1, NEVER, t_end);
    step(t_end + 3 - edge_n);

    // Reset pulse during SYS_RST
    d = edge_n;
    pll0 = 1'b0;
    push(0, S_WL, d + 3, NEVER);
    step(2);
    pll0 = 1'b1;
    p = edge_n;
    k = p + 3 + PR + PW + 1 + $urandom_range(0, 8);
    plan(0, p + 3, 0, 1'b1, k + 1, t_end);
    step(k - edge_n);
    rst0 = 1'b1;
    push(0, S_IDLE, k + 1, NEVER);
    step(1);
    rst0 = 1'b0;
    r = edge_n;
    push(0, S_WL, r + 1, NEVER);
    plan(0, r + 3, r + 3, 1'b1, NEVER, t_end);
    step(t_end + 3 - edge_n);

    // Late lock after reset
    for (int it = 0; it < 2; it++) begin
      late = (it == 0) ? 100 : $urandom_range(5, 150);
      rst0 = 1'b1;
      pll0 = 1'b0;
      push(0, S_IDLE, edge_n + 1, NEVER);
      step(3);
      rst0 = 1'b0;
      r = edge_n;
      push(0, S_WL, r + 1, NEVER);
      step(late);
      pll0 = 1'b1;
      p = edge_n;
      plan(0, imax(r, p) + 3, r + 3, 1'b1, NEVER, t_end);
      step(t_end + 3 - edge_n);
    end

    // Calibration timeout, retry, then calibration arriving on the timeout cycle
    rst0 = 1'b1;
    calib0 = 1'b0;
    push(0, S_IDLE, edge_n + 1, NEVER);
    step(2);
    rst0 = 1'b0;
    r = edge_n;
    push(0, S_WL, r + 1, NEVER);
    plan(0, r + 3, NEVER, 1'b1, NEVER, t_end);
    step(t_end + 2 - edge_n);
    retry0 = 1'b1;
    fr = edge_n;
    push(0, S_WL, fr + 1, NEVER);
    step(1);
    retry0 = 1'b0;
    w = fr + 2 + PR + PW;
    plan(0, fr + 2, w + CT, 1'b1, NEVER, t_end);
    step(w + CT - 3 - edge_n);
    calib0 = 1'b1;
    step(w + CT + 1 - edge_n);
    calib0 = 1'b0;
    step(t_end + 5 - edge_n);
  endtask

  task automatic proc1();
    int r, p, d, t_end;
    push(1, S_IDLE, 1, NEVER);
    step($urandom_range(2, 7));
    rst1 = 1'b0;
    r = edge_n;
    push(1, S_WL, r + 1, NEVER);
    plan(1, r + 3, 0, 1'b0, NEVER, t_end);
    step(t_end + 3 - edge_n);
    d = edge_n;
    pll1 = 1'b0;
    push(1, S_WL, d + 3, NEVER);
    step($urandom_range(1, 8));
    pll1 = 1'b1;
    p = edge_n;
    plan(1, p + 3, 0, 1'b0, NEVER, t_end);
    step(t_end + 3 - edge_n);
  endtask

  initial begin
    fork
      proc0();
      proc1();
    join
    step(5);
    chk("dut0_events_drained", q0.size(), 0);
    chk("dut1_events_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, edge %0d, required completion", edge_n);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
